// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline sequencing controller bus.
// Groups everything exchanged between the pipeline datapath and pipe_seq_ctrl:
//   - inputs to the controller: bus-busy flags, load hazard, interrupt lines/mask/enable,
//     and the EX/MEM instruction's valid bit, PC, delay-slot flag, exception code and ERET flag.
//   - outputs from the controller: per-register stall/flush, interrupt injection,
//     PC redirect (pc_load/new_pc), and the saved EPC, cause code and halt flag.
// modport master: the datapath side (drives requests, receives control).
// modport slave : the controller side.
interface pipe_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned INT_W  = 8
);
  logic              if_busy;
  logic              mem_busy;
  logic              ld_hazard;
  logic [INT_W-1:0]  irq;
  logic [INT_W-1:0]  int_mask;
  logic              int_en;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_pc;
  logic              mem_br_flag;
  logic [EXP_W-1:0]  mem_exp_code;
  logic              mem_eret;

  logic              if_stall;
  logic              id_stall;
  logic              ex_stall;
  logic              mem_stall;
  logic              if_flush;
  logic              id_flush;
  logic              ex_flush;
  logic              mem_flush;
  logic              int_detect;
  logic              pc_load;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] epc;
  logic [EXP_W-1:0]  exp_cause;
  logic              halted;

  modport master (
    output if_busy, mem_busy, ld_hazard, irq, int_mask, int_en,
           mem_en, mem_pc, mem_br_flag, mem_exp_code, mem_eret,
    input  if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           int_detect, pc_load, new_pc, epc, exp_cause, halted
  );

  modport slave (
    input  if_busy, mem_busy, ld_hazard, irq, int_mask, int_en,
           mem_en, mem_pc, mem_br_flag, mem_exp_code, mem_eret,
    output if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           int_detect, pc_load, new_pc, epc, exp_cause, halted
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline sequencing controller for the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Merges bus-busy and load-hazard stalls, detects unmasked interrupts, takes
// MEM-stage exceptions and ERET, and produces per-register stall/flush and PC redirect.
// Holds EPC and the cause code; halts the core on an exception raised inside the handler.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    pipe_seq_ctrl_if.slave  (requests in; stall/flush/redirect/epc/cause/halted out)
// stall/flush/int_detect/pc_load/new_pc are combinational; epc/exp_cause/halted are registered.
module pipe_seq_ctrl #(
  parameter int unsigned       ADDR_W     = 30,
  parameter int unsigned       EXP_W      = 3,
  parameter int unsigned       INT_W      = 8,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = '0
) (
  input  logic           clk,
  input  logic           reset,
  pipe_seq_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [EXP_W-1:0]  exp_cause_q, exp_cause_d;
  logic              halted_q, halted_d;

  logic [INT_W-1:0]  irq_live;
  logic              busy, exc, int_pend;
  // Bit order: [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB
  logic [3:0]        stall, flush;
  logic              pc_load;
  logic [ADDR_W-1:0] new_pc;

  assign irq_live = bus.irq & ~bus.int_mask;
  assign busy     = bus.if_busy | bus.mem_busy;
  assign exc      = bus.mem_en & (bus.mem_exp_code != '0);
  assign int_pend = bus.int_en & (|irq_live);

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    exp_cause_d = exp_cause_q;
    halted_d    = halted_q;
    stall       = '0;
    flush       = '0;
    pc_load     = 1'b0;
    new_pc      = epc_q;

    if (reset) begin
      flush = '1;
    end else if (state_q == ST_HALT || busy) begin
      // Busy freezes everything; any pending event is simply seen again next cycle.
      stall = '1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (exc) begin
            flush       = '1;
            pc_load     = 1'b1;
            new_pc      = EXC_VECTOR;
            exp_cause_d = bus.mem_exp_code;
            // An interrupt taken on a delay-slot instruction restarts at the branch.
            epc_d       = (bus.mem_exp_code == EXP_W'(1) && bus.mem_br_flag)
                          ? bus.mem_pc - ADDR_W'(1) : bus.mem_pc;
            state_d     = ST_DRAIN;
          end else if (bus.mem_eret) begin
            flush   = '1;
            pc_load = 1'b1;
          end else if (bus.ld_hazard) begin
            stall = 4'b1100;
            flush = 4'b0100;
          end
        end
        ST_DRAIN: begin
          flush   = '1;
          state_d = ST_HANDLER;
        end
        ST_HANDLER: begin
          if (exc) begin
            flush    = '1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else if (bus.mem_eret) begin
            flush   = '1;
            pc_load = 1'b1;
            state_d = ST_RUN;
          end else if (bus.ld_hazard) begin
            stall = 4'b1100;
            flush = 4'b0100;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      epc_q       <= '0;
      exp_cause_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      exp_cause_q <= exp_cause_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.if_stall   = stall[3];
  assign bus.id_stall   = stall[2];
  assign bus.ex_stall   = stall[1];
  assign bus.mem_stall  = stall[0];
  assign bus.if_flush   = flush[3];
  assign bus.id_flush   = flush[2];
  assign bus.ex_flush   = flush[1];
  assign bus.mem_flush  = flush[0];
  assign bus.int_detect = ~reset & (state_q == ST_RUN) & ~busy & ~exc & ~bus.mem_eret & int_pend;
  assign bus.pc_load    = pc_load;
  assign bus.new_pc     = new_pc;
  assign bus.epc        = epc_q;
  assign bus.exp_cause  = exp_cause_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;
  localparam logic [29:0] VEC = 30'h100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_seq_ctrl_if #(.ADDR_W(30), .EXP_W(3), .INT_W(8)) bus ();

  pipe_seq_ctrl #(.ADDR_W(30), .EXP_W(3), .INT_W(8), .EXC_VECTOR(VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ifb, memb, ldh;
    logic [7:0]  irq, mask;
    logic        ien, men;
    logic [29:0] pc;
    logic        br;
    logic [2:0]  code;
    logic        eret;
    logic [3:0]  e_stall, e_flush;
    logic        e_pcl;
    logic [29:0] e_npc;
    logic        e_intd;
    logic        chk_reg;
    logic [29:0] e_epc;
    logic [2:0]  e_cause;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, ifb, memb, ldh, input logic [7:0] irq, mask, input logic ien, men,
    input logic [29:0] pc, input logic br, input logic [2:0] code, input logic eret,
    input logic [3:0] st, fl, input logic pcl, input logic [29:0] npc, input logic intd,
    input logic cr, input logic [29:0] epc, input logic [2:0] cause, input logic halt);
    vec_t r;
    r.rst = rst; r.ifb = ifb; r.memb = memb; r.ldh = ldh; r.irq = irq; r.mask = mask;
    r.ien = ien; r.men = men; r.pc = pc; r.br = br; r.code = code; r.eret = eret;
    r.e_stall = st; r.e_flush = fl; r.e_pcl = pcl; r.e_npc = npc; r.e_intd = intd;
    r.chk_reg = cr; r.e_epc = epc; r.e_cause = cause; r.e_halt = halt;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    reset            = r.rst;
    bus.if_busy      = r.ifb;
    bus.mem_busy     = r.memb;
    bus.ld_hazard    = r.ldh;
    bus.irq          = r.irq;
    bus.int_mask     = r.mask;
    bus.int_en       = r.ien;
    bus.mem_en       = r.men;
    bus.mem_pc       = r.pc;
    bus.mem_br_flag  = r.br;
    bus.mem_exp_code = r.code;
    bus.mem_eret     = r.eret;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] st, input logic [3:0] fl,
                            input logic pcl, input logic [29:0] npc, input logic intd,
                            input logic cr, input logic [29:0] epc, input logic [2:0] cause,
                            input logic halt);
    chk({tag, " stall"}, {28'd0, bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}, {28'd0, st});
    chk({tag, " flush"}, {28'd0, bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}, {28'd0, fl});
    chk({tag, " pc_load"}, {31'd0, bus.pc_load}, {31'd0, pcl});
    if (pcl) chk({tag, " new_pc"}, {2'd0, bus.new_pc}, {2'd0, npc});
    chk({tag, " int_detect"}, {31'd0, bus.int_detect}, {31'd0, intd});
    if (cr) begin
      chk({tag, " epc"}, {2'd0, bus.epc}, {2'd0, epc});
      chk({tag, " exp_cause"}, {29'd0, bus.exp_cause}, {29'd0, cause});
      chk({tag, " halted"}, {31'd0, bus.halted}, {31'd0, halt});
    end
  endtask

  // Reference model: controller mode plus saved state, advanced once per clock.
  typedef enum int {M_RUN, M_DRAIN, M_HANDLER, M_HALT} mode_t;
  mode_t       m_mode;
  logic [29:0] m_epc;
  logic [2:0]  m_cause;
  logic        m_halt;

  task automatic model_expect(input vec_t r, output vec_t e);
    logic busy, exc, take_exc, take_eret;
    e = r;
    busy = r.ifb | r.memb;
    exc  = r.men && r.code != 3'd0;
    e.e_stall = 4'b0000; e.e_flush = 4'b0000; e.e_pcl = 1'b0; e.e_npc = m_epc; e.e_intd = 1'b0;
    e.chk_reg = 1'b1; e.e_epc = m_epc; e.e_cause = m_cause; e.e_halt = m_halt;
    if (r.rst) begin
      e.e_flush = 4'b1111;
    end else if (busy || m_mode == M_HALT) begin
      e.e_stall = 4'b1111;
    end else if (m_mode == M_DRAIN) begin
      e.e_flush = 4'b1111;
    end else begin
      take_exc  = exc;
      take_eret = !exc && r.eret;
      if (take_exc || take_eret) e.e_flush = 4'b1111;
      else if (r.ldh) begin e.e_stall = 4'b1100; e.e_flush = 4'b0100; end
      e.e_pcl = take_eret || (take_exc && m_mode == M_RUN);
      if (take_exc) e.e_npc = VEC;
      e.e_intd = m_mode == M_RUN && !exc && !r.eret && r.ien && ((r.irq & ~r.mask) != 8'd0);
    end
  endtask

  task automatic model_step(input vec_t r);
    logic [29:0] pcm1;
    pcm1 = r.pc - 30'd1;
    if (r.rst) begin
      m_mode = M_RUN; m_epc = '0; m_cause = '0; m_halt = 1'b0;
    end else if (!(r.ifb || r.memb)) begin
      case (m_mode)
        M_RUN:
          if (r.men && r.code != 0) begin
            m_cause = r.code;
            m_epc   = (r.code == 3'd1 && r.br) ? pcm1 : r.pc;
            m_mode  = M_DRAIN;
          end
        M_DRAIN: m_mode = M_HANDLER;
        M_HANDLER:
          if (r.men && r.code != 0) begin m_halt = 1'b1; m_mode = M_HALT; end
          else if (r.eret) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  initial begin
    vec_t r, e;
    //        rst ifb mb ldh irq    mask   ien men pc        br code eret  stall    flush    pcl npc          intd cr epc          cause halt
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 0, 30'h0,        3'd0, 0));
    tbl.push_back(v(1, 0, 0, 0, 8'h04, 8'h00, 1, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b1100, 4'b0100, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b1100, 4'b0100, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 30'h40,   0, 3'd2, 0, 4'b0000, 4'b1111, 1, VEC,          0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        0, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 1, 4'b0000, 4'b1111, 1, 30'h40,       0, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        1, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h04, 8'h04, 1, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        0, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h04, 8'h00, 1, 1, 30'h0,    1, 3'd1, 0, 4'b0000, 4'b1111, 1, VEC,          0, 1, 30'h40,       3'd2, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h3FFFFFFF, 3'd1, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 1, 4'b0000, 4'b1111, 1, 30'h3FFFFFFF, 0, 1, 30'h3FFFFFFF, 3'd1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 30'h55, 0, 3'd3, 0, 4'b1111, 4'b0000, 0, 30'h0,        0, 1, 30'h3FFFFFFF, 3'd1, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 30'h55,   0, 3'd3, 0, 4'b0000, 4'b1111, 1, VEC,          0, 1, 30'h3FFFFFFF, 3'd1, 0));
    tbl.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,        0, 1, 30'h55,       3'd3, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h55,       3'd3, 0));
    tbl.push_back(v(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b1100, 4'b0100, 0, 30'h0,        0, 1, 30'h55,       3'd3, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 30'h77,   0, 3'd5, 1, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h55,       3'd3, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,        0, 1, 30'h55,       3'd3, 1));
    tbl.push_back(v(0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 30'h0,    0, 3'd0, 1, 4'b1111, 4'b0000, 0, 30'h0,        0, 1, 30'h55,       3'd3, 1));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h55,       3'd3, 1));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 30'h12,   0, 3'd4, 1, 4'b0000, 4'b1111, 1, VEC,          0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b1111, 0, 30'h0,        0, 1, 30'h12,       3'd4, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 30'h0,    0, 3'd0, 0, 4'b0000, 4'b0000, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 0, 0, 8'h04, 8'h00, 1, 0, 30'h0,    0, 3'd0, 1, 4'b0000, 4'b1111, 1, 30'h0,        0, 1, 30'h0,        3'd0, 0));
    tbl.push_back(v(0, 0, 1, 1, 8'h04, 8'h00, 1, 0, 30'h0,    0, 3'd0, 0, 4'b1111, 4'b0000, 0, 30'h0,        0, 1, 30'h0,        3'd0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_pcl,
                 tbl[i].e_npc, tbl[i].e_intd, tbl[i].chk_reg, tbl[i].e_epc, tbl[i].e_cause,
                 tbl[i].e_halt);
    end

    // Randomized phase against the reference model, starting from a clean reset.
    r = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(r);
    model_step(r);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      r.rst  = ($urandom % 48) == 0;
      r.ifb  = ($urandom % 6) == 0;
      r.memb = ($urandom % 6) == 0;
      r.ldh  = ($urandom % 4) == 0;
      r.irq  = 8'($urandom);
      r.mask = 8'($urandom);
      r.ien  = 1'($urandom);
      r.men  = 1'($urandom);
      r.pc   = ($urandom % 8 == 0) ? 30'h0 : 30'($urandom);
      r.br   = 1'($urandom);
      r.code = ($urandom % 5 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r.eret = ($urandom % 6) == 0;
      drive(r);
      #1;
      model_expect(r, e);
      check_outs($sformatf("rnd%0d", i), e.e_stall, e.e_flush, e.e_pcl, e.e_npc, e.e_intd,
                 e.chk_reg, e.e_epc, e.e_cause, e.e_halt);
      model_step(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
